// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit holding register among 4 requesters.
// Grant, write and ack are all registered; busy is decoded from the state register.
module reg_share_arbiter #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic [3:0]         req,
   input  logic [4*WIDTH-1:0] wdata,
   output logic [3:0]         gnt,
   output logic [3:0]         ack,
   output logic [WIDTH-1:0]   q,
   output logic [1:0]         owner,
   output logic               busy
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_ACK
   } state_t;

   state_t           r_state;
   logic [1:0]       r_ptr;
   logic [1:0]       r_owner;
   logic [3:0]       r_gnt;
   logic [3:0]       r_ack;
   logic [WIDTH-1:0] r_q;

   logic [1:0]       w_sel;
   logic             w_any;
   logic [WIDTH-1:0] w_slice;

   // First set request bit searching from the priority pointer upward, mod 4
   always_comb begin
      w_sel = r_ptr;
      w_any = |req;
      for (int i = 3; i >= 0; i--) begin
         if (req[r_ptr + 2'(i)]) begin
            w_sel = r_ptr + 2'(i);
         end
      end
   end

   assign w_slice = wdata[r_owner*WIDTH +: WIDTH];

   // Arbitration FSM: IDLE picks, GRANT writes or aborts, ACK retires
   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state <= S_IDLE;
         r_ptr   <= 2'd0;
         r_owner <= 2'd0;
         r_gnt   <= 4'd0;
         r_ack   <= 4'd0;
         r_q     <= RESET_VAL;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_owner <= w_sel;
                  r_gnt   <= 4'b0001 << w_sel;
                  r_state <= S_GRANT;
               end
            end
            S_GRANT: begin
               if (req[r_owner]) begin
                  r_q     <= w_slice;
                  r_ack   <= 4'b0001 << r_owner;
                  r_state <= S_ACK;
               end else begin
                  r_gnt   <= 4'd0;
                  r_state <= S_IDLE;
               end
            end
            S_ACK: begin
               r_gnt   <= 4'd0;
               r_ack   <= 4'd0;
               r_ptr   <= r_owner + 2'd1;
               r_state <= S_IDLE;
            end
            default: begin
               r_gnt   <= 4'd0;
               r_ack   <= 4'd0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign gnt   = r_gnt;
   assign ack   = r_ack;
   assign q     = r_q;
   assign owner = r_owner;
   assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter with a transaction-level reference
// model checked every cycle plus hand-computed literal checkpoints.
module tb_reg_share_arbiter;

   localparam int W = 8;

   logic           clk;
   logic           Reset;
   logic [3:0]     req;
   logic [4*W-1:0] wdata;
   logic [3:0]     gnt;
   logic [3:0]     ack;
   logic [W-1:0]   q;
   logic [1:0]     owner;
   logic           busy;

   int n_vec = 0;
   int n_err = 0;

   reg_share_arbiter #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
      .clk   (clk),
      .Reset (Reset),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .ack   (ack),
      .q     (q),
      .owner (owner),
      .busy  (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a transfer is a phase counter 0=idle,1=granted,2=written
   int         m_ph;
   int         m_ptr;
   int         m_own;
   logic [3:0] m_gnt;
   logic [3:0] m_ack;
   logic [7:0] m_q;
   bit         m_ok = 1'b0;

   function automatic int pick(input logic [3:0] r, input int p);
      for (int i = 0; i < 4; i++) begin
         if (r[(p + i) % 4]) return (p + i) % 4;
      end
      return 0;
   endfunction

   always @(posedge clk) begin
      if (Reset) begin
         m_ph  <= 0;
         m_ptr <= 0;
         m_own <= 0;
         m_gnt <= 4'd0;
         m_ack <= 4'd0;
         m_q   <= 8'h00;
         m_ok  <= 1'b1;
      end else if (m_ok) begin
         if (m_ph == 0) begin
            if (req != 4'd0) begin
               m_own <= pick(req, m_ptr);
               m_gnt <= 4'(1 << pick(req, m_ptr));
               m_ph  <= 1;
            end
         end else if (m_ph == 1) begin
            if (req[m_own]) begin
               m_q   <= 8'((wdata >> (8 * m_own)) & 32'hFF);
               m_ack <= 4'(1 << m_own);
               m_ph  <= 2;
            end else begin
               m_gnt <= 4'd0;
               m_ph  <= 0;
            end
         end else begin
            m_gnt <= 4'd0;
            m_ack <= 4'd0;
            m_ptr <= (m_own + 1) % 4;
            m_ph  <= 0;
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_gnt", 32'(gnt), 32'(m_gnt));
         chk("m_ack", 32'(ack), 32'(m_ack));
         chk("m_q", 32'(q), 32'(m_q));
         chk("m_owner", 32'(owner), 32'(m_own));
         chk("m_busy", 32'(busy), 32'(m_ph != 0));
      end
   end

   task automatic nx();
      @(negedge clk);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      req   = 4'd0;
      nx();
      nx();
      Reset = 1'b0;
   endtask

   logic [7:0] rr_q [5];

   initial begin
      Reset = 1'b1;
      req   = 4'd0;
      wdata = '0;
      rr_q  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
      nx();
      nx();
      chk("rst_q", 32'(q), 32'h00);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      Reset = 1'b0;

      // single request from requester 2
      req = 4'b0100;
      wdata[16 +: 8] = 8'hA5;
      nx();
      chk("one_gnt", 32'(gnt), 32'b0100);
      chk("one_busy", 32'(busy), 32'h1);
      nx();
      chk("one_q", 32'(q), 32'hA5);
      chk("one_ack", 32'(ack), 32'b0100);
      chk("one_owner", 32'(owner), 32'd2);
      req = 4'd0;
      nx();
      chk("one_gnt_off", 32'(gnt), 32'h0);
      chk("one_idle", 32'(busy), 32'h0);
      chk("one_owner_hold", 32'(owner), 32'd2);

      // full load round robin
      do_reset();
      wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      req = 4'hF;
      for (int i = 0; i < 5; i++) begin
         nx();
         chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (i % 4)));
         nx();
         chk("rr_q", 32'(q), 32'(rr_q[i]));
         nx();
         chk("rr_gap", 32'(gnt), 32'h0);
      end
      req = 4'd0;
      nx();

      // pointer wrap after a transfer to requester 3
      req = 4'b1000;
      wdata[24 +: 8] = 8'h77;
      nx();
      chk("wrap_g3", 32'(gnt), 32'b1000);
      nx();
      chk("wrap_a3", 32'(ack), 32'b1000);
      req = 4'b1001;
      nx();
      nx();
      chk("wrap_first", 32'(gnt), 32'b0001);
      nx();
      chk("wrap_a0", 32'(ack), 32'b0001);
      req = 4'b1000;
      nx();
      nx();
      chk("wrap_second", 32'(gnt), 32'b1000);
      nx();
      req = 4'd0;
      nx();

      // transfer to requester 0 so the pointer sits at 1
      req = 4'b0001;
      wdata[0 +: 8] = 8'h3C;
      nx();
      nx();
      chk("prep_q", 32'(q), 32'h3C);
      req = 4'd0;
      nx();

      // withdrawal during GRANT
      req = 4'b0010;
      wdata[8 +: 8] = 8'h99;
      nx();
      chk("wd_gnt", 32'(gnt), 32'b0010);
      req = 4'd0;
      nx();
      chk("wd_gnt_off", 32'(gnt), 32'h0);
      chk("wd_no_ack", 32'(ack), 32'h0);
      chk("wd_q_hold", 32'(q), 32'h3C);
      chk("wd_idle", 32'(busy), 32'h0);
      req = 4'b0011;
      nx();
      chk("wd_ptr_kept", 32'(gnt), 32'b0010);
      nx();
      chk("wd_q_new", 32'(q), 32'h99);
      req = 4'd0;
      nx();

      // reset in the middle of a transfer
      req = 4'b0001;
      wdata[0 +: 8] = 8'hFF;
      nx();
      chk("mid_gnt", 32'(gnt), 32'b0001);
      Reset = 1'b1;
      nx();
      chk("mid_q", 32'(q), 32'h00);
      chk("mid_gnt_off", 32'(gnt), 32'h0);
      chk("mid_ack", 32'(ack), 32'h0);
      chk("mid_idle", 32'(busy), 32'h0);
      Reset = 1'b0;
      req = 4'b1001;
      nx();
      chk("mid_ptr0", 32'(gnt), 32'b0001);
      nx();
      chk("mid_q_after", 32'(q), 32'hFF);
      req = 4'd0;
      nx();

      // simultaneous reset and request
      Reset = 1'b1;
      req = 4'b0100;
      nx();
      chk("rr_vs_rst_gnt", 32'(gnt), 32'h0);
      chk("rr_vs_rst_busy", 32'(busy), 32'h0);
      Reset = 1'b0;
      req = 4'd0;
      nx();

      // wdata changes after the sampling edge are ignored
      req = 4'b0010;
      wdata[8 +: 8] = 8'h5A;
      nx();
      nx();
      chk("win_q", 32'(q), 32'h5A);
      wdata[8 +: 8] = 8'hC3;
      req = 4'd0;
      nx();
      chk("win_q_late", 32'(q), 32'h5A);
      nx();
      chk("win_q_hold", 32'(q), 32'h5A);
      nx();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Round-robin controller that shares one WIDTH-bit holding register (a bank of D flip-flops) among 4 requesters.
- Each requester raises req with its data; the arbiter grants one requester at a time, writes that requester's data into the shared register and returns a one-cycle ack.
- Sits between the lab's requester blocks and the shared register; it is the only writer of q.

Parameters:
- WIDTH, 8, width of the shared register and of each requester's data slice.
- RESET_VAL, 0, value loaded into q on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset. Clock is clk.
- req  input  4  request lines; bit i is requester i.
- wdata  input  4*WIDTH  flattened data; requester i owns bits [i*WIDTH +: WIDTH].
- gnt  output  4  registered one-hot grant; all zero when idle.
- ack  output  4  registered one-hot write-done pulse, one cycle long.
- q  output  WIDTH  shared register contents.
- owner  output  2  index of the last or current granted requester.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (sampled at a rising edge of clk while Reset=1), applied regardless of state:
  - state=IDLE, gnt=0, ack=0, q=RESET_VAL, owner=0, busy=0.
  - Priority pointer ptr=0.
  - Reset mid-transfer aborts the transfer; q takes RESET_VAL, not the pending data.
- States: IDLE, GRANT, ACK. All outputs are registered; busy is decoded from state.
- IDLE:
  - If req is nonzero, select the first set bit searching ptr, ptr+1, ... mod 4.
  - owner <= selected index; gnt <= onehot(selected); state <= GRANT.
  - If req is zero, remain in IDLE with all outputs held.
- GRANT (one cycle):
  - If req[owner]=1: q <= wdata slice of owner; ack <= onehot(owner); state <= ACK.
  - If req[owner]=0 (requester withdrew): abort. gnt <= 0, q unchanged, no ack, ptr unchanged, state <= IDLE.
  - Other req bits are ignored in this state.
- ACK (one cycle):
  - gnt <= 0, ack <= 0, ptr <= (owner+1) mod 4, state <= IDLE.
  - q holds the written value.
- Timing for a successful transfer:
  - req sampled at edge k.
  - gnt high from edge k to edge k+2 (two cycles).
  - q and ack update at edge k+1; ack is high for exactly the second gnt cycle.
  - Back in IDLE after edge k+2.
  - Minimum spacing between successive grants is 3 cycles.
- Requester protocol:
  - Hold req and wdata stable until ack is seen, then drop req.
  - A req still high when the arbiter returns to IDLE is treated as a new request and competes normally.
- wdata is sampled only in GRANT, at edge k+1; changes at any other time have no effect.
- Fairness: the pointer advances only on a completed write. With all 4 requesting continuously, grant order is 0,1,2,3,0,... and no requester waits more than 3 other transfers.
- Simultaneous Reset and req: Reset wins; no grant is issued that cycle.
- owner holds its value in IDLE; it is not cleared after a transfer.

Test Plan:
- Reset, then a single request:
  - Stimulus: assert Reset for 2 cycles; check q=RESET_VAL (0x00), gnt=0, ack=0, busy=0. Then req=4'b0100 with slice2=0xA5.
  - Required: gnt=4'b0100 at edge k; q=0xA5 and ack=4'b0100 at edge k+1; owner=2; idle again at k+2.
- Round robin under full load:
  - Stimulus: req=4'b1111 held, slices 0x11, 0x22, 0x33, 0x44.
  - Required: grants in order 0,1,2,3,0; q sequence 0x11, 0x22, 0x33, 0x44, 0x11; grants 3 cycles apart.
- Pointer wrap:
  - Stimulus: after a completed grant to requester 3, assert req=4'b1001.
  - Required: requester 0 is granted first (ptr wrapped to 0), then requester 3.
- Withdrawal during GRANT:
  - Stimulus: req=4'b0010, drop req[1] in the GRANT cycle.
  - Required: no ack, q unchanged, gnt cleared next edge, ptr stays 1 (a later req=4'b0011 grants requester 1 first).
- Reset mid-transfer:
  - Stimulus: assert Reset during GRANT with slice0=0xFF.
  - Required: q=0x00, gnt=0, ack=0, state IDLE, ptr=0 after the edge; ack is never asserted.
- wdata sampling window:
  - Stimulus: change slice1 from 0x5A to 0xC3 after edge k+1 of a requester-1 transfer.
  - Required: q=0x5A; the late change is ignored.
